// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: default geometry, counter
// init values, the saturating-counter step and PC index/tag extraction.
package btb_pkg;

    function automatic int idx_w_of(input int entries);
        return $clog2(entries);
    endfunction

    // Counters are carried as 4 bits (the widest legal CNT_W) and cast back by the caller.
    function automatic logic [3:0] weak_t(input int cnt_w);
        return 4'(32'd1 << (cnt_w - 1));
    endfunction

    function automatic logic [3:0] weak_nt(input int cnt_w);
        return 4'((32'd1 << (cnt_w - 1)) - 32'd1);
    endfunction

    function automatic logic [3:0] sat_update(input logic [3:0] cnt, input logic taken,
                                              input int cnt_w);
        logic [3:0] max_v;
        max_v = 4'((32'd1 << cnt_w) - 32'd1);
        if (taken) return (cnt >= max_v) ? cnt : cnt + 4'd1;
        else       return (cnt == 4'd0)  ? cnt : cnt - 4'd1;
    endfunction

    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w,
                                           input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    localparam int         ENTRIES_DEF = 64;
    localparam int         CNT_W_DEF   = 2;
    localparam int         TAG_W_DEF   = 8;
    localparam int         IDX_W       = idx_w_of(ENTRIES_DEF);
    localparam logic [3:0] WEAK_T      = weak_t(CNT_W_DEF);
    localparam logic [3:0] WEAK_NT     = weak_nt(CNT_W_DEF);

endpackage

// File: rtl/btb_sat_counter.sv
// Per-entry saturating direction counter: resets weakly not-taken, loads
// weakly taken on allocation, and steps up/down on training.
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             train,
    input  logic             alloc,
    input  logic             taken,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] INIT_T  = CNT_W'(weak_t(CNT_W));
    localparam logic [CNT_W-1:0] INIT_NT = CNT_W'(weak_nt(CNT_W));

    // NOTE: state is written with non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= INIT_NT;
        else if (alloc) cnt <= INIT_T;
        else if (train) cnt <= CNT_W'(sat_update(4'(cnt), taken, CNT_W));
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Optional BTB_STATS_EN adds lookup/hit/update/mispredict statistics counters.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredNPCF,
    output logic        HitF,
    input  logic        UpdateEnE,
    input  logic [31:0] UpdatePCE,
    input  logic [31:0] UpdateTargetE,
    input  logic        UpdateTakenE,
    input  logic        FlushBTB
`ifdef BTB_STATS_EN
    ,
    input  logic        UpdateMispredE,
    output logic [31:0] StatLookups,
    output logic [31:0] StatHits,
    output logic [31:0] StatUpdates,
    output logic [31:0] StatMispredicts
`endif
);

    localparam int IW = idx_w_of(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt      [ENTRIES];

    logic [IW-1:0]    idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_e, upd, train, alloc;

    assign idx_f = IW'(pc_index(PCF, IW));
    assign tag_f = TAG_W'(pc_tag(PCF, IW, TAG_W));
    assign idx_e = IW'(pc_index(UpdatePCE, IW));
    assign tag_e = TAG_W'(pc_tag(UpdatePCE, IW, TAG_W));

    // Lookup reads pre-edge state only; a same-cycle update is not bypassed.
    assign HitF       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredTakenF = HitF && cnt[idx_f][CNT_W-1];
    assign PredNPCF   = PredTakenF ? target_q[idx_f] : PCF + 32'd4;

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign upd   = UpdateEnE && !FlushBTB;
    assign train = upd && hit_e;
    assign alloc = upd && !hit_e && UpdateTakenE;

    // NOTE: tag/target arrays are reset only so simulation starts from known
    // values; correctness depends solely on valid_q being cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else begin
            if (FlushBTB) begin
                valid_q <= '0;
            end else if (alloc) begin
                valid_q[idx_e] <= 1'b1;
                tag_q[idx_e]   <= tag_e;
            end
            if (upd && UpdateTakenE) target_q[idx_e] <= UpdateTargetE;
        end
    end

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        logic sel;
        assign sel = (idx_e == IW'(i));
        btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .train (train && sel),
            .alloc (alloc && sel),
            .taken (UpdateTakenE),
            .cnt   (cnt[i])
        );
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StatLookups     <= '0;
            StatHits        <= '0;
            StatUpdates     <= '0;
            StatMispredicts <= '0;
        end else begin
            StatLookups <= StatLookups + 32'd1;
            if (HitF)                        StatHits        <= StatHits + 32'd1;
            if (upd)                         StatUpdates     <= StatUpdates + 32'd1;
            if (UpdateEnE && UpdateMispredE) StatMispredicts <= StatMispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer (default 64x2-bit, 8-bit tag).
// With BTB_STATS_EN defined it also checks the statistics counters.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredNPCF;
    logic        HitF;
    logic        UpdateEnE;
    logic [31:0] UpdatePCE;
    logic [31:0] UpdateTargetE;
    logic        UpdateTakenE;
    logic        FlushBTB;
`ifdef BTB_STATS_EN
    logic        UpdateMispredE;
    logic [31:0] StatLookups, StatHits, StatUpdates, StatMispredicts;
`endif

    branch_target_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .PCF           (PCF),
        .PredTakenF    (PredTakenF),
        .PredNPCF      (PredNPCF),
        .HitF          (HitF),
        .UpdateEnE     (UpdateEnE),
        .UpdatePCE     (UpdatePCE),
        .UpdateTargetE (UpdateTargetE),
        .UpdateTakenE  (UpdateTakenE),
        .FlushBTB      (FlushBTB)
`ifdef BTB_STATS_EN
        ,
        .UpdateMispredE  (UpdateMispredE),
        .StatLookups     (StatLookups),
        .StatHits        (StatHits),
        .StatUpdates     (StatUpdates),
        .StatMispredicts (StatMispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       total  = 0;
    int       passed = 0;

    task automatic push(input string name, input logic [31:0] exp);
        sb_item_t it;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_item_t it;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed 0x%08h expected an entry", obs);
            return;
        end
        it = sb.pop_front();
        assert (obs === it.exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", it.name, obs, it.exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lookup(input string name, input logic [31:0] pc,
                                 input logic hit, input logic tk, input logic [31:0] npc);
        PCF = pc;
        push({name, "_hit"},   32'(hit));
        push({name, "_taken"}, 32'(tk));
        push({name, "_npc"},   npc);
        #1;
        pop_check(32'(HitF));
        pop_check(32'(PredTakenF));
        pop_check(PredNPCF);
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        UpdateEnE     = 1'b1;
        UpdatePCE     = pc;
        UpdateTargetE = tgt;
        UpdateTakenE  = tk;
        tick();
        UpdateEnE     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PCF = '0; UpdateEnE = 1'b0; UpdatePCE = '0;
        UpdateTargetE = '0; UpdateTakenE = 1'b0; FlushBTB = 1'b0;
`ifdef BTB_STATS_EN
        UpdateMispredE = 1'b0;
`endif
        #2;
        expect_lookup("in_reset", 32'h100, 1'b0, 1'b0, 32'h104);
        tick();
        rst = 1'b0;
        expect_lookup("post_reset", 32'h100, 1'b0, 1'b0, 32'h104);

        // Allocate; lookup in the same cycle must still miss.
        UpdateEnE = 1'b1; UpdatePCE = 32'h100; UpdateTargetE = 32'h80; UpdateTakenE = 1'b1;
        expect_lookup("same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
        tick();
        UpdateEnE = 1'b0;
        expect_lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h80);

        // Counter 2 -> 1 -> 0 -> 0 (floor), then up to saturation at 3.
        train(32'h100, 32'hDEAD_BEE0, 1'b0);
        expect_lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 32'hDEAD_BEE0, 1'b0);
        expect_lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 32'hDEAD_BEE0, 1'b0);
        expect_lookup("nt_floor", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 32'h80, 1'b1);
        expect_lookup("up_from_floor", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 32'h80, 1'b1);
        expect_lookup("up_to_2", 32'h100, 1'b1, 1'b1, 32'h80);
        train(32'h100, 32'h80, 1'b1);
        train(32'h100, 32'h80, 1'b1);
        train(32'h100, 32'h80, 1'b1);
        train(32'h100, 32'h80, 1'b1);
        // From saturation at 3 one not-taken leaves 2 (taken); target must be kept.
        train(32'h100, 32'hDEAD_BEE0, 1'b0);
        expect_lookup("sat_then_nt", 32'h100, 1'b1, 1'b1, 32'h80);
        train(32'h100, 32'hDEAD_BEE0, 1'b0);
        expect_lookup("sat_nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 32'h90, 1'b1);
        expect_lookup("retarget", 32'h100, 1'b1, 1'b1, 32'h90);

        // Never-taken miss is not allocated.
        train(32'h104, 32'h40, 1'b0);
        expect_lookup("miss_nt", 32'h104, 1'b0, 1'b0, 32'h108);

        // Same index, different tag replaces the entry.
        train(32'h200, 32'h200, 1'b1);
        expect_lookup("alias_evict", 32'h100, 1'b0, 1'b0, 32'h104);
        expect_lookup("alias_new",   32'h200, 1'b1, 1'b1, 32'h200);
        expect_lookup("low_bits",    32'h202, 1'b1, 1'b1, 32'h200);
        expect_lookup("pc_wrap",     32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Flush wins over a simultaneous allocating update.
        UpdateEnE = 1'b1; UpdatePCE = 32'h300; UpdateTargetE = 32'h700; UpdateTakenE = 1'b1;
        FlushBTB  = 1'b1;
        tick();
        UpdateEnE = 1'b0; FlushBTB = 1'b0;
        expect_lookup("flush_old", 32'h200, 1'b0, 1'b0, 32'h204);
        expect_lookup("flush_upd", 32'h300, 1'b0, 1'b0, 32'h304);

        // Asynchronous reset mid-cycle, and an update held in reset is dropped.
        train(32'h400, 32'h500, 1'b1);
        expect_lookup("pre_rst", 32'h400, 1'b1, 1'b1, 32'h500);
        rst = 1'b1;
        expect_lookup("async_rst", 32'h400, 1'b0, 1'b0, 32'h404);
        train(32'h400, 32'h500, 1'b1);
        rst = 1'b0;
        expect_lookup("upd_in_rst", 32'h400, 1'b0, 1'b0, 32'h404);

`ifdef BTB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // Ten counted edges: 3 hits, 2 updates, 1 mispredict.
        PCF = 32'h100;
        UpdateEnE = 1'b1; UpdatePCE = 32'h100; UpdateTargetE = 32'h80;
        UpdateTakenE = 1'b1; UpdateMispredE = 1'b1;
        tick();
        UpdateEnE = 1'b0; UpdateMispredE = 1'b0;
        tick();
        tick();
        UpdateEnE = 1'b1;
        tick();
        UpdateEnE = 1'b0;
        PCF = 32'h500;
        for (int i = 0; i < 6; i++) tick();
        push("stat_lookups", 32'd10);
        push("stat_hits",    32'd3);
        push("stat_updates", 32'd2);
        push("stat_mispred", 32'd1);
        pop_check(StatLookups);
        pop_check(StatHits);
        pop_check(StatUpdates);
        pop_check(StatMispredicts);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised direct-mapped branch target buffer with saturating-counter direction prediction for the RV32 pipeline.
- Sits beside NPC_Generator in IF. Looks up the fetch PC combinationally and supplies a predicted next PC.
- EX-stage branch resolution (BranchE/target) trains it on the following clock edge.
- Successor to static not-taken fetch: the number of entries, counter width and tag width are all configurable.

Parameters:
- ENTRIES, 64, number of entries; power of two, minimum 2. IDX_W = log2(ENTRIES).
- CNT_W, 2, width of the saturating direction counter; legal range 1..4.
- TAG_W, 8, partial tag width taken from PC[IDX_W+2 +: TAG_W]; IDX_W+2+TAG_W must be ≤32.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- PCF  in  32  fetch-stage PC to look up.
- PredTakenF  out  1  prediction for PCF is taken.
- PredNPCF  out  32  predicted next PC: the stored target if PredTakenF, else PCF+4.
- HitF  out  1  PCF matches a valid entry.
- UpdateEnE  in  1  a resolved conditional branch is in EX this cycle.
- UpdatePCE  in  32  PC of the resolved branch.
- UpdateTargetE  in  32  computed branch target (BrNPC).
- UpdateTakenE  in  1  actual outcome (BranchE).
- FlushBTB  in  1  invalidate all entries (fence.i / context switch).

Behaviour:
- Index and tag:
  - idx = PC[IDX_W+1:2]; tag = PC[IDX_W+2 +: TAG_W]; PC[1:0] is ignored.
  - Per entry: valid, tag, target[31:0], cnt[CNT_W-1:0].
- Lookup (combinational, zero latency):
  - HitF = valid[idx] & (tag[idx]==tagF).
  - PredTakenF = HitF & cnt[idx][CNT_W-1].
  - PredNPCF = PredTakenF ? target[idx] : PCF+4, with 32-bit wrap.
- Update (registered, effective next cycle). Applied when UpdateEnE=1:
  - Hit & taken: cnt saturating increment (max 2^CNT_W-1); target <= UpdateTargetE.
  - Hit & not taken: cnt saturating decrement (min 0); target unchanged.
  - Miss & taken: allocate or replace. valid<=1, tag, target, cnt <= 2^(CNT_W-1) (weakly taken).
  - Miss & not taken: no change. Never-taken branches are not allocated.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents; there is no write-through bypass.
- FlushBTB=1: all valid bits cleared at the next edge. Counters and targets are left as they are. If FlushBTB and UpdateEnE are both high, the flush wins and the update is discarded.
- Reset (async, any time including mid-update):
  - All valid=0; all cnt = 2^(CNT_W-1)-1 (weakly not taken).
  - Targets/tags are don't-care but must be reset to 0 for deterministic simulation.
  - Outputs during reset: HitF=0, PredTakenF=0, PredNPCF=PCF+4.
- CNT_W=1: the counter degenerates to a last-outcome bit. Allocation sets it to 1; reset sets it to 0.
- Aliasing: a partial-tag false hit is legal and is trained like a true hit.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, the block adds:
  - Outputs StatLookups, StatHits, StatUpdates, StatMispredicts (32 bits each, wrap on overflow, reset to 0).
  - Input UpdateMispredE, 1 bit: the EX prediction was wrong; counted only when UpdateEnE=1.
- Counting rules:
  - StatLookups increments every non-reset cycle.
  - StatHits increments when HitF=1.
  - StatUpdates increments when UpdateEnE=1 and FlushBTB=0.
- When undefined: these ports and registers are absent, and the functional behaviour is identical.

Decomposition:
- Shared package btb_pkg holds:
  - Localparams IDX_W and the counter init values (WEAK_T, WEAK_NT).
  - Function sat_update(cnt, taken) for the CNT_W counter.
  - Tag/index extraction helpers.
- One sub-module, btb_sat_counter: a per-entry saturating counter with reset value and init-on-allocate. It is instantiated ENTRIES times via generate.

Test Plan:
- Reset, then PCF=0x0000_0100 → HitF=0, PredTakenF=0, PredNPCF=0x0000_0104.
- Update PC=0x100, target=0x0000_0080, taken=1, then look up 0x100 next cycle → HitF=1, PredTakenF=1 (cnt=2), PredNPCF=0x80.
- Same branch: two not-taken updates → cnt 2→1→0 and PredTakenF=0. Four taken updates → cnt saturates at 3, not 0.
- Update PC=0x100 taken, then PC=0x100+4·ENTRIES (same idx, different tag) taken with target 0x200 → lookup 0x100 gives HitF=0; the other PC predicts 0x200.
- FlushBTB and UpdateEnE (miss, taken) in the same cycle → next cycle every lookup gives HitF=0. Asserting rst mid-sequence immediately forces HitF=0.
- With BTB_STATS_EN defined: 10 cycles with 3 hits, 2 updates and 1 UpdateMispredE → StatLookups=10, StatHits=3, StatUpdates=2, StatMispredicts=1.
